// File: rtl/dmem_arbiter_pkg.sv
// dmem_pkg: FSM state encoding, requester ids and memory size default shared by the arbiter files
package dmem_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_RESP = 2'd2} state_e;
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;
  localparam int MEM_WORDS_DEF = 21;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: C_*/D_* requester handshakes and MEM_* Data_Memory bus; slave = arbiter side, master = requesters+memory side
interface dmem_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              C_REQ, C_RW, C_ACK, C_ERR;
  logic [ADDR_W-1:0] C_ADDR;
  logic [DATA_W-1:0] C_WDATA, C_RDATA;
  logic              D_REQ, D_RW, D_ACK, D_ERR;
  logic [ADDR_W-1:0] D_ADDR;
  logic [DATA_W-1:0] D_WDATA, D_RDATA;
  logic              MEM_EN, MEM_RW;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_DIN, MEM_DOUT;
  modport slave (
    input  C_REQ, C_RW, C_ADDR, C_WDATA, D_REQ, D_RW, D_ADDR, D_WDATA, MEM_DOUT,
    output C_RDATA, C_ACK, C_ERR, D_RDATA, D_ACK, D_ERR, MEM_EN, MEM_RW, MEM_ADDR, MEM_DIN
  );
  modport master (
    output C_REQ, C_RW, C_ADDR, C_WDATA, D_REQ, D_RW, D_ADDR, D_WDATA, MEM_DOUT,
    input  C_RDATA, C_ACK, C_ERR, D_RDATA, D_ACK, D_ERR, MEM_EN, MEM_RW, MEM_ADDR, MEM_DIN
  );
endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: combinational 2-way round-robin pick; req_i[1:0], ptr_i (preferred id) -> valid_o, win_id_o
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic       valid_o,
  output logic       win_id_o
);
  assign valid_o  = |req_i;
  assign win_id_o = (&req_i) ? ptr_i : req_i[1];
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of single-port Data_Memory; CLK/RST, bus (C_*/D_* requesters, MEM_* memory), BUSY, GNT_ID
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = MEM_WORDS_DEF
) (
  input  logic           CLK,
  input  logic           RST,
  dmem_arbiter_if.slave  bus,
  output logic           BUSY,
  output logic           GNT_ID
);
  state_e            state_q;
  logic              ptr_q, gnt_q, rw_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              valid, win, rw_d, err_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              acc, c_win, d_win;
  rr_pick2 u_pick (
    .req_i    ({bus.D_REQ, bus.C_REQ}),
    .ptr_i    (ptr_q),
    .valid_o  (valid),
    .win_id_o (win)
  );
  assign rw_d    = win ? bus.D_RW    : bus.C_RW;
  assign addr_d  = win ? bus.D_ADDR  : bus.C_ADDR;
  assign wdata_d = win ? bus.D_WDATA : bus.C_WDATA;
  assign err_d   = (addr_d[1:0] != 2'b00) || ((addr_d >> 2) >= ADDR_W'(MEM_WORDS));
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      ptr_q   <= REQ_CPU;
      gnt_q   <= REQ_CPU;
      rw_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (valid) begin
          gnt_q   <= win;
          rw_q    <= rw_d;
          addr_q  <= addr_d;
          wdata_q <= wdata_d;
          err_q   <= err_d;
          state_q <= ST_ACCESS;
        end
        ST_ACCESS: begin
          rdata_q <= (err_q || rw_q) ? '0 : bus.MEM_DOUT;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          ptr_q   <= ~gnt_q;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign acc   = state_q == ST_ACCESS;
  assign c_win = (state_q == ST_RESP) && (gnt_q == REQ_CPU);
  assign d_win = (state_q == ST_RESP) && (gnt_q == REQ_DBG);
  // RST gates EN combinationally so a reset landing on the access cycle kills the write
  assign bus.MEM_EN   = acc & ~err_q & ~RST;
  assign bus.MEM_RW   = acc & rw_q;
  assign bus.MEM_ADDR = acc ? addr_q  : '0;
  assign bus.MEM_DIN  = acc ? wdata_q : '0;
  assign bus.C_ACK    = c_win & ~err_q;
  assign bus.C_ERR    = c_win & err_q;
  assign bus.C_RDATA  = c_win ? rdata_q : '0;
  assign bus.D_ACK    = d_win & ~err_q;
  assign bus.D_ERR    = d_win & err_q;
  assign bus.D_RDATA  = d_win ? rdata_q : '0;
  assign BUSY   = state_q != ST_IDLE;
  assign GNT_ID = gnt_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a 21-word behavioural Data_Memory
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_init = 1'b1;
  logic        busy, gnt_id;
  logic [31:0] mem [21];
  int          n_cmp = 0;
  int          n_bad = 0;
  dmem_arbiter_if bus ();
  dmem_arbiter dut (.CLK(clk), .RST(rst), .bus(bus), .BUSY(busy), .GNT_ID(gnt_id));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 21; i++) mem[i] <= 32'h1000_0000 + i;
    end else if (bus.MEM_EN && bus.MEM_RW && (bus.MEM_ADDR >> 2) < 21) begin
      mem[bus.MEM_ADDR[6:2]] <= bus.MEM_DIN;
    end
  end
  assign bus.MEM_DOUT = ((bus.MEM_ADDR >> 2) < 21) ? mem[bus.MEM_ADDR[6:2]] : 32'h0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic xact(input logic id, input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic en, input logic ack, input logic err, input logic [31:0] rd);
    if (id) begin
      bus.D_REQ = 1'b1; bus.D_RW = rw; bus.D_ADDR = addr; bus.D_WDATA = wdata;
    end else begin
      bus.C_REQ = 1'b1; bus.C_RW = rw; bus.C_ADDR = addr; bus.C_WDATA = wdata;
    end
    tick();
    check("acc_busy", busy, 1);
    check("acc_mem_en", bus.MEM_EN, en);
    if (en) begin
      check("acc_mem_rw", bus.MEM_RW, rw);
      check("acc_mem_addr", bus.MEM_ADDR, addr);
    end
    tick();
    check("resp_gnt", gnt_id, id);
    check("resp_ack", id ? bus.D_ACK : bus.C_ACK, ack);
    check("resp_err", id ? bus.D_ERR : bus.C_ERR, err);
    check("resp_rdata", id ? bus.D_RDATA : bus.C_RDATA, rd);
    check("resp_other_ack", id ? bus.C_ACK : bus.D_ACK, 0);
    bus.C_REQ = 1'b0;
    bus.D_REQ = 1'b0;
    tick();
    check("idle_busy", busy, 0);
  endtask
  initial begin
    bus.C_REQ = 0; bus.C_RW = 0; bus.C_ADDR = 0; bus.C_WDATA = 0;
    bus.D_REQ = 0; bus.D_RW = 0; bus.D_ADDR = 0; bus.D_WDATA = 0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_gnt", gnt_id, 0);
    check("rst_mem_en", bus.MEM_EN, 0);
    check("rst_c_ack", bus.C_ACK, 0);
    check("rst_d_rdata", bus.D_RDATA, 0);
    rst = 1'b0;
    mem_init = 1'b0;
    // continuous contention: C at 0x0, D at 0x4, grants must alternate starting with C
    bus.C_REQ = 1; bus.C_RW = 0; bus.C_ADDR = 32'h0;
    bus.D_REQ = 1; bus.D_RW = 0; bus.D_ADDR = 32'h4;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_acc_gnt", gnt_id, k % 2);
      check("rr_acc_addr", bus.MEM_ADDR, (k % 2) ? 32'h4 : 32'h0);
      tick();
      check("rr_c_ack", bus.C_ACK, (k % 2) == 0);
      check("rr_d_ack", bus.D_ACK, (k % 2) == 1);
      check("rr_rdata", (k % 2) ? bus.D_RDATA : bus.C_RDATA, (k % 2) ? 32'h1000_0001 : 32'h1000_0000);
      if (k == 3) begin
        bus.C_REQ = 0;
        bus.D_REQ = 0;
      end
      tick();
      check("rr_idle_ack", bus.C_ACK | bus.D_ACK, 0);
    end
    xact(0, 1, 32'h8, 32'hDEAD_BEEF, 1, 1, 0, 32'h0);
    xact(0, 0, 32'h8, 32'h0, 1, 1, 0, 32'hDEAD_BEEF);
    xact(1, 0, 32'h54, 32'h0, 0, 0, 1, 32'h0);
    xact(1, 0, 32'h50, 32'h0, 1, 1, 0, 32'h1000_0014);
    xact(0, 1, 32'h6, 32'h0BAD_0BAD, 0, 0, 1, 32'h0);
    xact(0, 0, 32'h4, 32'h0, 1, 1, 0, 32'h1000_0001);
    // reset landing on the access cycle of a write to 0xC
    bus.C_REQ = 1; bus.C_RW = 1; bus.C_ADDR = 32'hC; bus.C_WDATA = 32'h1234_5678;
    tick();
    check("rw_acc_en_pre", bus.MEM_EN, 1);
    rst = 1'b1;
    #1;
    check("rw_acc_en_rst", bus.MEM_EN, 0);
    bus.C_REQ = 0;
    tick();
    check("rw_no_ack", bus.C_ACK, 0);
    check("rw_busy", busy, 0);
    check("rw_gnt", gnt_id, 0);
    rst = 1'b0;
    bus.C_REQ = 1; bus.C_RW = 0; bus.C_ADDR = 32'hC;
    bus.D_REQ = 1; bus.D_RW = 0; bus.D_ADDR = 32'h0;
    tick();
    check("post_rst_gnt", gnt_id, 0);
    check("post_rst_addr", bus.MEM_ADDR, 32'hC);
    tick();
    check("post_rst_c_ack", bus.C_ACK, 1);
    check("post_rst_d_ack", bus.D_ACK, 0);
    check("post_rst_rdata", bus.C_RDATA, 32'h1000_0003);
    bus.C_REQ = 0;
    bus.D_REQ = 0;
    tick();
    // lone requester held high: ACKs every third cycle
    bus.D_REQ = 1; bus.D_RW = 0; bus.D_ADDR = 32'h10;
    for (int t = 1; t <= 9; t++) begin
      tick();
      check("lone_d_ack", bus.D_ACK, (t % 3) == 2);
      if ((t % 3) == 2) check("lone_d_rdata", bus.D_RDATA, 32'h1000_0004);
      if (t == 8) bus.D_REQ = 0;
    end
    check("lone_end_busy", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single-port Data_Memory between two requesters: requester 0 (CPU load/store unit) and requester 1 (debug/program loader).
- Each request is arbitrated round-robin and driven to the memory as one EN/RW/ADDr/Din access.
- Read data is registered, and exactly one ACK (or ERR) pulse is returned to the winning requester.
- Sits between the pipeline MEM stage / debug port and Data_Memory.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data width.
- MEM_WORDS, 21, number of implemented words; valid byte addresses are 0 .. 4*MEM_WORDS-4.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- C_REQ  in  1  requester 0 request; held until C_ACK or C_ERR.
- C_RW  in  1  requester 0 direction: 1 = write, 0 = read.
- C_ADDR  in  ADDR_W  requester 0 byte address.
- C_WDATA  in  DATA_W  requester 0 write data.
- C_RDATA  out  DATA_W  read data, valid while C_ACK=1.
- C_ACK  out  1  one-cycle completion pulse.
- C_ERR  out  1  one-cycle error pulse.
- D_REQ, D_RW, D_ADDR, D_WDATA, D_RDATA, D_ACK, D_ERR: requester 1, same directions, widths and meaning as the C_ ports.
- MEM_EN  out  1  to Data_Memory EN.
- MEM_RW  out  1  to Data_Memory RW.
- MEM_ADDR  out  ADDR_W  to Data_Memory ADDr.
- MEM_DIN  out  DATA_W  to Data_Memory Din.
- MEM_DOUT  in  DATA_W  from Data_Memory Dout; combinational read data.
- BUSY  out  1  high whenever the FSM is not in IDLE.
- GNT_ID  out  1  id of the current or last granted requester.

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Encoding is 2 bits, state register only.
- IDLE:
  - If any REQ is high, pick the winner via the round-robin pointer PTR and latch winner id, RW, ADDR and WDATA into internal registers.
  - Compute err = (ADDR[1:0] != 0) or (ADDR >> 2 >= MEM_WORDS), then go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS (exactly one cycle):
  - MEM_EN = ~err & ~RST. MEM_RW, MEM_ADDR and MEM_DIN come from the latched registers.
  - Write commits at the closing CLK edge.
  - Read: MEM_DOUT is captured into the RDATA register at the closing edge; RDATA is zeroed if err or write.
  - Next state is RESP.
- RESP (one cycle):
  - Winner's ACK = ~err and ERR = err. All other ACK/ERR outputs are 0.
  - The winner's RDATA port shows the RDATA register; the non-winner RDATA port shows 0.
  - PTR is set to ~winner, so the winner becomes lowest priority. Next state is IDLE.
- Outside ACCESS: MEM_EN = 0, MEM_RW = 0, MEM_ADDR = 0, MEM_DIN = 0.
- Latency:
  - REQ sampled high in IDLE at edge N; access occurs in cycle N+1; ACK is high in cycle N+2.
  - Throughput is one transaction per 3 cycles.
  - A REQ still high in the IDLE cycle after ACK starts a new transaction; the requester must drop REQ in the ACK cycle for single-shot behaviour.
- Arbitration:
  - PTR resets to 0 (requester 0 preferred).
  - Simultaneous requests go to PTR; a single request always wins.
  - Requester 1 cannot be starved: under continuous contention, grants alternate C, D, C, D.
- Requests changing while not in IDLE are ignored; the latched values are used.
- Reset (RST=1, any state):
  - Next state is IDLE, PTR = 0, GNT_ID = 0, latched registers cleared, all ACK/ERR/RDATA = 0.
  - MEM_EN is forced to 0 in the same cycle, so a reset during ACCESS suppresses the write.
- No partial-word or byte-lane accesses: word only.

Decomposition:
- Shared package dmem_pkg holds:
  - FSM state encodings ST_IDLE=0, ST_ACCESS=1, ST_RESP=2.
  - Requester ids REQ_CPU=0, REQ_DBG=1.
  - The MEM_WORDS default.
- One natural sub-module, rr_pick2: combinational 2-way round-robin pick.
  - Inputs: req[1:0], ptr.
  - Outputs: valid, win_id.

Test Plan:
- Reset, then C_REQ=1, C_RW=1, C_ADDR=0x8, C_WDATA=0xDEADBEEF for one transaction:
  - MEM_EN=1, MEM_RW=1, MEM_ADDR=0x8 in cycle 1; C_ACK=1 in cycle 2.
  - A following read of 0x8 returns C_RDATA=0xDEADBEEF with C_ACK.
- C_REQ and D_REQ held high together, both reads of 0x0 and 0x4: grants run C, D, C, D; ACKs are 3 cycles apart; GNT_ID toggles; no simultaneous ACKs.
- D_REQ, read, D_ADDR=0x54 (word 21, out of range): MEM_EN stays 0; D_ERR=1 and D_ACK=0 in cycle 2; D_RDATA=0.
- C_REQ, write, C_ADDR=0x6 (misaligned): C_ERR pulse; no memory write; a subsequent read of 0x4 returns the prior contents.
- Write of 0x12345678 to 0xC, with RST asserted during the ACCESS cycle:
  - MEM_EN=0 in that cycle; no ACK.
  - After reset, a read of 0xC returns the old value; PTR=0, so a simultaneous C/D request grants C.
- D_REQ only, three back-to-back transactions with REQ held: D_ACK in cycles 2, 5 and 8; round-robin does not block a lone requester.
